// File: rtl/updown_seq_ctrl_if.sv
// Host-side handshake and status bundle for the up/down sequencing controller.
// The host drives the request fields; the controller drives count and status.
interface updown_seq_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             bounce;
  logic             stop;
  logic [WIDTH-1:0] q;
  logic             m;
  logic             cnt_en;
  logic             busy;
  logic             done;

  modport master (
    output start, target, bounce, stop,
    input  q, m, cnt_en, busy, done
  );

  modport slave (
    input  start, target, bounce, stop,
    output q, m, cnt_en, busy, done
  );
endinterface

// File: rtl/updown_seq_ctrl.sv
// Sequencing controller for an up/down counter: walks q to a requested target,
// optionally bounces back to the origin, then pulses done for one cycle.
module updown_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic              clk,
  input  logic              clr,
  updown_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] org_q;
  logic             bnc_q;
  logic             leg_q;
  logic             m_q;
  logic             busy_q;
  logic             cnt_en_q;
  logic             done_q;

  logic [WIDTH-1:0] goal;
  logic [WIDTH-1:0] q_step;

  // First leg heads for the target, the bounce leg heads back to the origin.
  assign goal   = leg_q ? org_q : tgt_q;
  assign q_step = (state_q == RUN_DN) ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));

  // NOTE: every register here updates with <= so all next-state terms read
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      q_q      <= '0;
      tgt_q    <= '0;
      org_q    <= '0;
      bnc_q    <= 1'b0;
      leg_q    <= 1'b0;
      m_q      <= 1'b0;
      busy_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start) begin
            tgt_q <= bus.target;
            org_q <= q_q;
            bnc_q <= bus.bounce;
            leg_q <= 1'b0;
            if (bus.target > q_q) begin
              state_q  <= RUN_UP;
              m_q      <= 1'b0;
              busy_q   <= 1'b1;
              cnt_en_q <= 1'b1;
            end else if (bus.target < q_q) begin
              state_q  <= RUN_DN;
              m_q      <= 1'b1;
              busy_q   <= 1'b1;
              cnt_en_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RUN_UP, RUN_DN: begin
          if (bus.stop) begin
            // Abort wins over the count step: q keeps its current value.
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_en_q <= 1'b0;
          end else begin
            q_q <= q_step;
            if (q_step == goal) begin
              if (!leg_q && bnc_q && (org_q != tgt_q)) begin
                leg_q   <= 1'b1;
                state_q <= (state_q == RUN_UP) ? RUN_DN : RUN_UP;
                m_q     <= ~m_q;
              end else begin
                state_q  <= DONE;
                busy_q   <= 1'b0;
                cnt_en_q <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          cnt_en_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q      = q_q;
  assign bus.m      = m_q;
  assign bus.cnt_en = cnt_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
- Sequencing controller for the 3-bit up/down counter datapath.
- Accepts a start request with a target value and drives the counter toward the target in the correct direction. Optionally "bounces" back to the origin value, then reports completion.
- Contains the count register, direction (mode) logic and a small FSM; sits between a host/requester and any logic consuming q.

Parameters:
- WIDTH, 3, counter and target width in bits.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous reset, active-high.
- start  input  1  request pulse/level; sampled only in IDLE.
- target  input  WIDTH  destination value, latched on accepted start.
- bounce  input  1  latched on accepted start; 1 = return to origin after reaching target.
- stop  input  1  abort; sampled in RUN_UP/RUN_DN.
- q  output  WIDTH  current count.
- m  output  1  direction: 0 = up, 1 = down. Same encoding as the counter mode pin.
- cnt_en  output  1  high in cycles where q changes at the next edge.
- busy  output  1  high while counting.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (clr=1, asynchronous, any state): state=IDLE, q=0, m=0, cnt_en=0, busy=0, done=0, tgt=0, org=0, bnc=0, leg=0. Reset mid-run discards the operation; no done is produced.
- States: IDLE, RUN_UP, RUN_DN, DONE. Outputs are registered or state-decoded; no combinational path from inputs to outputs.
- IDLE:
  - stop=1 has priority: start is ignored.
  - Otherwise, on an edge with start=1: tgt<=target, org<=q, bnc<=bounce, leg<=0.
  - Next state is RUN_UP if target>q, RUN_DN if target<q, and DONE if target==q. Bounce is irrelevant in the equal case.
- RUN_UP: busy=1, cnt_en=1, m=0. Each edge q<=q+1.
- RUN_DN: busy=1, cnt_en=1, m=1. Each edge q<=q-1.
- Leg end, on the edge where the next q equals the current goal (goal = tgt when leg=0, org when leg=1):
  - If leg=0, bnc=1 and org!=tgt: leg<=1 and reverse direction (RUN_UP <-> RUN_DN). No idle cycle between legs.
  - Otherwise: DONE.
- stop=1 in RUN_UP/RUN_DN: at that edge, state<=IDLE and q holds (stop beats count). done is not asserted. busy drops the next cycle.
- DONE: done=1, busy=0, cnt_en=0, q holds. The following edge returns to IDLE unconditionally. start during DONE is ignored.
- start while busy: ignored; target/bounce changes mid-run have no effect.
- Latency: with d=|target-q0|, q==target d edges after the start edge. done is high during the cycle after that edge, i.e. start edge + d + 1.
  - Bounce adds d further edges.
  - Equal case: done in the cycle after the start edge.
- Arithmetic:
  - q is unsigned WIDTH bits.
  - No wrap-around ever occurs, because direction comes from the magnitude compare. 0 and 2^WIDTH-1 are reachable endpoints but never crossed.
- m holds its last value in IDLE/DONE; it is 0 after reset.

Test Plan:
- Reset: assert clr asynchronously mid-cycle during RUN_UP (q=3) -> q=0, busy=0, done=0, m=0 immediately, without waiting for clk.
- Up run: q=0, start with target=5, bounce=0 -> busy for 5 cycles, q=1,2,3,4,5, m=0, done pulse one cycle, then IDLE with q=5.
- Down + bounce: q=6, start with target=2, bounce=1 -> q=5,4,3,2 (m=1), then 3,4,5,6 (m=0, no gap), single done, final q=6.
- Boundaries: q=0, target=7 -> 7 steps to 7, no wrap. Then target=0 -> 7 steps down to 0. target==q=4 -> done the next cycle with no q change, busy never set.
- Abort/priority: during RUN_UP at q=2 toward 6, assert stop -> q stays 2, IDLE, no done. start and stop together in IDLE -> stays IDLE.
- Ignored requests: start with a different target while busy and during DONE -> no effect on the current sequence or its final q.
